// File: rtl/uart_prog_loader.sv
// uart_prog_loader: boot-time program download over an 8N1 UART link.
// A length header N (4 bytes, little-endian) is followed by N little-endian
// 32-bit words. Each word becomes one instruction-memory write. done or err
// latches when the download ends, and only reset clears it.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 200,
  parameter int ADDR_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_HDR, L_BODY, L_DONE, L_ERR} ld_state_t;

  rx_state_t        rx_state;
  ld_state_t        ld_state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             byte_valid;
  logic             frame_err;
  logic             start_ok;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_word;
  logic [IDX_W-1:0] word_total;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      full_word;

  // The byte that completes a word or header, joined with the three bytes gathered before it
  assign full_word = {shreg, asm_word};

  // Two-flop synchronizer for the asynchronous receive line, idling high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rx_sync <= rx_meta;
    end
  end

  // Byte receiver: mid-bit sampling, false-start rejection, stop-bit framing check
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state   <= R_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      start_ok   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      start_ok   <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) rx_state <= R_START;
        end
        R_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!rx_sync) begin
              rx_state <= R_DATA;
              start_ok <= 1'b1;
            end else begin
              rx_state <= R_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= R_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt  <= '0;
            rx_state <= R_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Loader: header decode, word assembly, write pulses and sticky completion status
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ld_state   <= L_HDR;
      byte_cnt   <= '0;
      asm_word   <= '0;
      word_total <= '0;
      word_idx   <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      we <= 1'b0;
      case (ld_state)
        L_HDR, L_BODY: begin
          if (start_ok) busy <= 1'b1;
          if (frame_err) begin
            ld_state <= L_ERR;
            err      <= 1'b1;
            busy     <= 1'b0;
          end else if (we && (word_idx == word_total)) begin
            ld_state <= L_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
          end else if (byte_valid) begin
            asm_word <= {shreg, asm_word[23:8]};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              if (ld_state == L_HDR) begin
                word_total <= IDX_W'(full_word);
                if (full_word == 32'd0) begin
                  ld_state <= L_DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                end else if (full_word > 32'(MAX_WORDS)) begin
                  ld_state <= L_ERR;
                  err      <= 1'b1;
                  busy     <= 1'b0;
                end else begin
                  ld_state <= L_BODY;
                end
              end else begin
                we       <= 1'b1;
                waddr    <= ADDR_W'(word_idx);
                wdata    <= full_word;
                word_idx <= word_idx + 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: scoreboard bench for the UART program loader.
// Stimulus queues the writes each stream should produce; a negedge monitor
// pops and compares every we pulse against that queue.
module tb_uart_prog_loader;

  localparam int CPB  = 8;
  localparam int MAXW = 200;
  localparam int AW   = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          CLK;
  logic          RST;
  logic          RXD;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;

  wr_t exp_q[$];
  wr_t exp_item;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  arm_done = 1'b0;
  bit  check_done_next = 1'b0;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS(MAXW),
    .ADDR_W(AW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RXD(RXD),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .err(err)
  );

  // Free-running system clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_output(input string name, input logic exp_busy, input logic exp_done, input logic exp_err);
    check_bit($sformatf("%s busy", name), busy, exp_busy);
    check_bit($sformatf("%s done", name), done, exp_done);
    check_bit($sformatf("%s err", name), err, exp_err);
  endtask

  task automatic check_all_zero(input string name);
    check_bit($sformatf("%s we", name), we, 1'b0);
    check_val($sformatf("%s waddr", name), 32'(waddr), 32'd0);
    check_val($sformatf("%s wdata", name), wdata, 32'd0);
    check_output(name, 1'b0, 1'b0, 1'b0);
  endtask

  // One 8N1 frame; inputs change on the falling edge, away from DUT sampling
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = stop_bit;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) apply_stimulus(w[8*i +: 8], 1'b1);
  endtask

  task automatic push_write(input int a, input logic [31:0] d);
    wr_t item;
    item.addr = AW'(a);
    item.data = d;
    exp_q.push_back(item);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    exp_q.delete();
    arm_done = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL %s drain: got %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  function automatic logic [31:0] bulk_word(input int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'(i);
  endfunction

  // Scoreboard monitor: every write must match the head of the expected queue
  always @(negedge CLK) begin
    if (RST) begin
      check_done_next = 1'b0;
    end else begin
      if (check_done_next) begin
        check_bit("done one cycle after final write", done, 1'b1);
        check_bit("busy one cycle after final write", busy, 1'b0);
        check_done_next = 1'b0;
      end
      if (we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL unexpected_write: got write addr %0d data %h, required no write", waddr, wdata);
        end else begin
          exp_item = exp_q.pop_front();
          check_val("write address", 32'(waddr), 32'(exp_item.addr));
          check_val("write data", wdata, exp_item.data);
          if (exp_q.size() == 0 && arm_done) begin
            check_bit("done low during final write", done, 1'b0);
            check_done_next = 1'b1;
            arm_done = 1'b0;
          end
        end
      end
      n_checks++;
      if (done && err) begin
        n_errors++;
        $display("[TB] FAIL done_err_exclusive: got done=1 err=1, required at most one set");
      end
    end
  end

  // Watchdog so a stuck DUT still reaches the summary line
  initial begin
    #2000000;
    n_errors++;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence
  initial begin
    RST = 1'b1;
    RXD = 1'b1;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    @(negedge CLK);

    $display("[TB] two-word program");
    push_write(0, 32'h20010008);
    push_write(1, 32'h08000000);
    arm_done = 1'b1;
    send_word(32'd2);
    check_bit("two-word busy after header", busy, 1'b1);
    send_word(32'h20010008);
    send_word(32'h08000000);
    wait_drain("two-word", 50 * CPB);
    repeat (3) @(negedge CLK);
    check_output("two-word end", 1'b0, 1'b1, 1'b0);
    check_val("two-word last waddr", 32'(waddr), 32'd1);

    $display("[TB] empty program");
    do_reset();
    check_all_zero("reset after two-word");
    send_word(32'd0);
    repeat (3) @(negedge CLK);
    check_output("empty header", 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'hAA, 1'b1);
    repeat (2 * CPB) @(negedge CLK);
    check_output("byte after done", 1'b0, 1'b1, 1'b0);

    $display("[TB] oversize header");
    do_reset();
    send_word(32'h000000C9);
    repeat (3) @(negedge CLK);
    check_output("oversize header", 1'b0, 1'b0, 1'b1);

    $display("[TB] framing error");
    do_reset();
    send_word(32'd1);
    apply_stimulus(8'h11, 1'b1);
    apply_stimulus(8'h22, 1'b0);
    repeat (12 * CPB) @(negedge CLK);
    check_output("framing error", 1'b0, 1'b0, 1'b1);
    send_word(32'h12345678);
    repeat (2 * CPB) @(negedge CLK);
    check_output("bytes after framing error", 1'b0, 1'b0, 1'b1);

    $display("[TB] glitch rejection");
    do_reset();
    RXD = 1'b0;
    repeat (3) @(negedge CLK);
    RXD = 1'b1;
    repeat (3 * CPB) @(negedge CLK);
    check_output("after glitch", 1'b0, 1'b0, 1'b0);
    push_write(0, 32'hEFBEADDE);
    arm_done = 1'b1;
    send_word(32'd1);
    send_word(32'hEFBEADDE);
    wait_drain("post-glitch", 50 * CPB);
    repeat (3) @(negedge CLK);
    check_output("post-glitch end", 1'b0, 1'b1, 1'b0);

    $display("[TB] reset mid-word");
    do_reset();
    push_write(0, 32'h0A0B0C0D);
    send_word(32'd3);
    send_word(32'h0A0B0C0D);
    wait_drain("pre-reset word", 50 * CPB);
    apply_stimulus(8'h01, 1'b1);
    apply_stimulus(8'h02, 1'b1);
    check_bit("busy before mid-word reset", busy, 1'b1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_all_zero("async mid-word reset");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    push_write(0, 32'hCAFEF00D);
    push_write(1, 32'h13579BDF);
    arm_done = 1'b1;
    send_word(32'd2);
    send_word(32'hCAFEF00D);
    send_word(32'h13579BDF);
    wait_drain("reload", 50 * CPB);
    repeat (3) @(negedge CLK);
    check_output("reload end", 1'b0, 1'b1, 1'b0);

    $display("[TB] maximum-size program");
    do_reset();
    for (int i = 0; i < MAXW; i++) push_write(i, bulk_word(i));
    arm_done = 1'b1;
    send_word(32'h000000C8);
    for (int i = 0; i < MAXW; i++) send_word(bulk_word(i));
    wait_drain("max-size", 50 * CPB);
    repeat (3) @(negedge CLK);
    check_output("max-size end", 1'b0, 1'b1, 1'b0);
    check_val("max-size last waddr", 32'(waddr), 32'd199);
    check_val("max-size last wdata", wdata, bulk_word(MAXW - 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Serial program loader and the writer side of the core's instruction memory. It receives an 8N1 UART byte stream from the host, assembles little-endian 32-bit words and issues single-cycle writes into instruction memory. It signals completion so the core can be released from INIT. It replaces compile-time instruction images with a boot-time download.

Parameters:
CLKS_PER_BIT, 868, system clocks per UART bit (100 MHz / 115200); must be >= 4
MAX_WORDS, 200, instruction memory depth in words; larger program lengths are rejected
ADDR_W, 16, width of the write address

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-high reset
RXD  input  1  UART receive line, idle high, asynchronous to CLK
we  output  1  instruction-memory write strobe, one cycle per word
waddr  output  ADDR_W  word address of the current write
wdata  output  32  word to write
busy  output  1  download in progress
done  output  1  sticky; program fully written
err  output  1  sticky; framing error or oversize program

Behaviour:
- Reset: clock domain is CLK only; reset is asynchronous, active-high. Assertion at any time, including mid-byte or mid-word, immediately clears everything. Outputs go to we=0, waddr=0, wdata=0, busy=0, done=0, err=0. Both FSMs return to idle and all counters and the byte shift register clear.
- Input sync: RXD passes through a 2-flop synchronizer whose flops reset to 1; the byte FSM uses only the synchronized value.
- Byte FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE -> R_START when the synchronized line is 0.
  - R_START: wait CLKS_PER_BIT/2 clocks, then sample. A 0 goes to R_DATA. A 1 is a false start and returns to R_IDLE with no error.
  - R_DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
  - R_STOP: sample after CLKS_PER_BIT clocks. A 1 gives a byte_valid pulse for one cycle. A 0 is a framing error. Either way the FSM returns to R_IDLE.
- Loader FSM states: L_HDR, L_BODY, L_DONE, L_ERR.
  - L_HDR: collect 4 bytes little-endian into word count N.
    - N == 0: go to L_DONE.
    - N > MAX_WORDS: go to L_ERR.
    - Otherwise go to L_BODY.
  - L_BODY: collect 4 bytes per word; byte 0 goes to wdata[7:0], byte 3 to wdata[31:24].
    - On the cycle after the 4th byte_valid: we=1 for exactly 1 cycle, with waddr = word index (0..N-1) and wdata = assembled word.
    - waddr increments after each write.
    - wdata and waddr hold their last values while we=0.
  - The cycle after the N-th write pulse: go to L_DONE.
  - L_DONE: done=1, busy=0. All further RX bytes are ignored. Exit only via RST.
  - A framing error in L_HDR or L_BODY goes to L_ERR. A partially assembled word is discarded and never written.
  - L_ERR: err=1, busy=0, no further writes. Exit only via RST.
- busy: set on the first valid start bit after reset; cleared on entering L_DONE or L_ERR.
- Boundaries:
  - Back-to-back bytes with no idle gap (stop bit followed directly by start bit) must be received.
  - N == MAX_WORDS is legal; N == MAX_WORDS+1 is an error.
  - done and err are never both 1.
  - A write is never issued to an address >= N.
- Latency:
  - Last stop-bit sample to the we pulse: 1 cycle.
  - The we pulse for the final word to done rising: 1 cycle.

Test Plan:
- CLKS_PER_BIT=16: header 02 00 00 00, then bytes 08 00 01 20 and 00 00 00 08. Required: two we pulses, waddr 0 with wdata 32'h20010008, then waddr 1 with wdata 32'h08000000. done=1 one cycle after the second pulse; err=0 throughout.
- Header 00 00 00 00 -> done=1 with no we pulse; a subsequent byte AA produces no write and done stays 1.
- Header C9 00 00 00 (201) with MAX_WORDS=200 -> err=1, busy=0, no we pulse. With header C8 00 00 00, 200 words follow and the last write has waddr=199.
- Framing error: header 01 00 00 00, then data bytes 11 22 with the second byte's stop bit driven 0. Required: err=1, no we pulse, and later bytes are ignored.
- Glitch on RXD low for 3 clocks at CLKS_PER_BIT=16 -> no byte_valid, no err. A following correct byte stream loads normally.
- RST asserted mid-word (after 2 body bytes) -> all outputs 0 immediately. A fresh full stream then loads from waddr 0.
